// File: rtl/hdb3_enc_ctrl_if.sv
// hdb3_enc_ctrl_if: upstream word handshake plus serial line and aligned marker outputs
interface hdb3_enc_ctrl_if #(parameter int DATA_W = 8);
    logic              i_enable;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              i_last;
    logic              o_ready;
    logic              o_ser_data;
    logic              o_ser_en;
    logic              o_ser_dflag;
    logic              o_underrun;
    logic              o_enc_valid;
    logic              o_enc_sof;
    logic              o_enc_eof;
    logic              o_busy;
    modport master (
        output i_enable, i_data, i_valid, i_last,
        input  o_ready, o_ser_data, o_ser_en, o_ser_dflag, o_underrun,
        input  o_enc_valid, o_enc_sof, o_enc_eof, o_busy
    );
    modport slave (
        input  i_enable, i_data, i_valid, i_last,
        output o_ready, o_ser_data, o_ser_en, o_ser_dflag, o_underrun,
        output o_enc_valid, o_enc_sof, o_enc_eof, o_busy
    );
endinterface

// File: rtl/hdb3_enc_ctrl.sv
// hdb3_enc_ctrl: serializes words MSB-first into the HDB3 encoder, filling underruns and
// flushing the encoder pipeline, with SOF/EOF/valid markers delayed to the encoded output.
module hdb3_enc_ctrl #(
    parameter int DATA_W   = 8,
    parameter int PIPE_LAT = 6
) (
    input logic            i_clk,
    input logic            i_rst,
    hdb3_enc_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, UNDERRUN = 2'd2, FLUSH = 2'd3;
    localparam int CW = $clog2(DATA_W);
    localparam int FW = $clog2(PIPE_LAT + 1);
    logic [1:0]          st, st_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [FW-1:0]       fcnt, fcnt_n;
    logic [DATA_W-1:0]   sh, sh_n;
    logic                last_q, last_n, sof_q, sof_n, eof_q, eof_n;
    logic                sd_n, und_n, en_n, busy_n, last_bit, acc;
    logic [PIPE_LAT-1:0] dv, ds, de, dv_n, ds_n, de_n;
    always_comb begin
        last_bit    = cnt == CW'(DATA_W - 1);
        bus.o_ready = st == IDLE ? bus.i_enable : st == UNDERRUN ? 1'b1 : (st == SHIFT) && last_bit && !last_q;
        acc         = bus.i_valid && bus.o_ready;
        st_n        = st;
        cnt_n       = cnt;
        fcnt_n      = fcnt;
        sh_n        = sh;
        last_n      = last_q;
        sd_n        = 1'b0;
        sof_n       = 1'b0;
        eof_n       = 1'b0;
        und_n       = 1'b0;
        if (acc) begin
            st_n   = SHIFT;
            cnt_n  = '0;
            sd_n   = bus.i_data[DATA_W-1];
            sh_n   = bus.i_data << 1;
            last_n = bus.i_last;
            sof_n  = st == IDLE;
        end else if (st == SHIFT && !last_bit) begin
            cnt_n = cnt + 1'b1;
            sd_n  = sh[DATA_W-1];
            sh_n  = sh << 1;
            eof_n = last_q && cnt == CW'(DATA_W - 2);
        end else if (st == SHIFT) begin
            // word exhausted with nothing accepted: flush after the final word, otherwise fill
            st_n   = last_q ? FLUSH : UNDERRUN;
            fcnt_n = '0;
            und_n  = !last_q;
        end else if (st == FLUSH) begin
            st_n   = fcnt == FW'(PIPE_LAT - 1) ? IDLE : FLUSH;
            fcnt_n = fcnt + 1'b1;
        end
        en_n   = st_n != IDLE;
        dv_n   = PIPE_LAT'({dv, bus.o_ser_en});
        ds_n   = PIPE_LAT'({ds, sof_q});
        de_n   = PIPE_LAT'({de, eof_q});
        busy_n = en_n || (|dv_n);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st              <= IDLE;
            cnt             <= '0;
            fcnt            <= '0;
            sh              <= '0;
            last_q          <= 1'b0;
            sof_q           <= 1'b0;
            eof_q           <= 1'b0;
            dv              <= '0;
            ds              <= '0;
            de              <= '0;
            bus.o_ser_data  <= 1'b0;
            bus.o_ser_en    <= 1'b0;
            bus.o_ser_dflag <= 1'b0;
            bus.o_underrun  <= 1'b0;
            bus.o_busy      <= 1'b0;
        end else begin
            st              <= st_n;
            cnt             <= cnt_n;
            fcnt            <= fcnt_n;
            sh              <= sh_n;
            last_q          <= last_n;
            sof_q           <= sof_n;
            eof_q           <= eof_n;
            dv              <= dv_n;
            ds              <= ds_n;
            de              <= de_n;
            bus.o_ser_data  <= sd_n;
            bus.o_ser_en    <= en_n;
            bus.o_ser_dflag <= st_n == SHIFT;
            bus.o_underrun  <= und_n;
            bus.o_busy      <= busy_n;
        end
    end
    assign bus.o_enc_valid = dv[PIPE_LAT-1];
    assign bus.o_enc_sof   = ds[PIPE_LAT-1];
    assign bus.o_enc_eof   = de[PIPE_LAT-1];
endmodule

// File: tb/tb_hdb3_enc_ctrl.sv
// tb_hdb3_enc_ctrl: queue-based line model checked every cycle, directed bursts with
// literal expectations, random traffic, and a DATA_W=2/PIPE_LAT=1 instance.
module tb_hdb3_enc_ctrl;
    localparam int W = 8;
    localparam int P = 6;
    localparam int N = 8192;
    typedef struct packed {logic d; logic pay; logic sof; logic eof;} lbit_t;
    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1, done2 = 1'b0;
    int   cyc = 0, rst_c = 0, checks = 0, errors = 0;
    hdb3_enc_ctrl_if #(.DATA_W(W)) bus ();
    hdb3_enc_ctrl_if #(.DATA_W(2)) bus2 ();
    hdb3_enc_ctrl #(.DATA_W(W), .PIPE_LAT(P)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    hdb3_enc_ctrl #(.DATA_W(2), .PIPE_LAT(1)) dut2 (.i_clk(clk), .i_rst(rst2), .bus(bus2));
    always #5 clk = ~clk;
    lbit_t q[$];
    lbit_t e;
    logic  in_burst = 0, last_seen = 0, prev_fill = 0, en, fill, m_acc;
    bit m_d[N], m_df[N], m_en[N], m_sof[N], m_eof[N], m_und[N];
    bit g_d[N], g_en[N], g_df[N], g_sof[N], g_eof[N], g_ev[N], g_rdy[N], g_und[N], g_busy[N];
    bit g2_d[N], g2_en[N], g2_sof[N], g2_eof[N], g2_ev[N];
    function automatic logic exp_ready();
        return !in_burst ? bus.i_enable : last_seen ? 1'b0 : q.size() == 0;
    endfunction
    function automatic logic dl(input int sel);
        int c = cyc - P;
        if (c < rst_c) return 1'b0;
        return sel == 0 ? m_en[c] : sel == 1 ? m_sof[c] : m_eof[c];
    endfunction
    function automatic logic exp_busy();
        for (int j = 0; j <= P; j++) if (cyc - j >= rst_c && m_en[cyc-j]) return 1'b1;
        return 1'b0;
    endfunction
    // the line is a queue of pending bits; empty queue mid-burst means fill zeros
    always @(posedge clk) begin
        m_acc = bus.i_valid && exp_ready();
        cyc++;
        if (rst) begin
            q.delete();
            in_burst  = 0;
            last_seen = 0;
            prev_fill = 0;
            rst_c     = cyc;
            e = '0; en = 0; fill = 0;
        end else begin
            if (m_acc) begin
                for (int k = 0; k < W; k++) begin
                    e.d   = bus.i_data[W-1-k];
                    e.pay = 1'b1;
                    e.sof = !in_burst && k == 0;
                    e.eof = bus.i_last && k == W - 1;
                    q.push_back(e);
                end
                e = '0;
                if (bus.i_last) repeat (P) q.push_back(e);
                in_burst  = 1;
                last_seen = bus.i_last;
            end
            if (q.size() != 0) begin
                e = q.pop_front(); en = 1; fill = 0;
            end else if (in_burst && !last_seen) begin
                e = '0; en = 1; fill = 1;
            end else begin
                e = '0; en = 0; fill = 0; in_burst = 0; last_seen = 0;
            end
        end
        m_d[cyc] = e.d; m_df[cyc] = e.pay; m_sof[cyc] = e.sof; m_eof[cyc] = e.eof;
        m_en[cyc] = en; m_und[cyc] = fill && !prev_fill;
        prev_fill = fill;
    end
    task automatic chk(input string nm, input logic a, input logic x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0b exp=%0b", nm, cyc, a, x);
        end
    endtask
    task automatic chkv(input string nm, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, a, x);
        end
    endtask
    always @(negedge clk) if (cyc > 0) begin
        g_d[cyc] = bus.o_ser_data; g_en[cyc] = bus.o_ser_en; g_df[cyc] = bus.o_ser_dflag;
        g_sof[cyc] = bus.o_enc_sof; g_eof[cyc] = bus.o_enc_eof; g_ev[cyc] = bus.o_enc_valid;
        g_rdy[cyc] = bus.o_ready; g_und[cyc] = bus.o_underrun; g_busy[cyc] = bus.o_busy;
        g2_d[cyc] = bus2.o_ser_data; g2_en[cyc] = bus2.o_ser_en; g2_sof[cyc] = bus2.o_enc_sof;
        g2_eof[cyc] = bus2.o_enc_eof; g2_ev[cyc] = bus2.o_enc_valid;
        chk("ready", bus.o_ready, exp_ready());
        chk("ser_data", bus.o_ser_data, m_d[cyc]);
        chk("ser_en", bus.o_ser_en, m_en[cyc]);
        chk("ser_dflag", bus.o_ser_dflag, m_df[cyc]);
        chk("underrun", bus.o_underrun, m_und[cyc]);
        chk("enc_valid", bus.o_enc_valid, dl(0));
        chk("enc_sof", bus.o_enc_sof, dl(1));
        chk("enc_eof", bus.o_enc_eof, dl(2));
        chk("busy", bus.o_busy, exp_busy());
    end
    function automatic logic [31:0] gv(input int sel, input int s, input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++)
            case (sel)
                0:  v[k] = g_d[s+k];
                1:  v[k] = g_en[s+k];
                2:  v[k] = g_df[s+k];
                3:  v[k] = g_sof[s+k];
                4:  v[k] = g_eof[s+k];
                5:  v[k] = g_ev[s+k];
                6:  v[k] = g_rdy[s+k];
                7:  v[k] = g_und[s+k];
                8:  v[k] = g_busy[s+k];
                10: v[k] = g2_d[s+k];
                11: v[k] = g2_en[s+k];
                13: v[k] = g2_sof[s+k];
                14: v[k] = g2_eof[s+k];
                default: v[k] = g2_ev[s+k];
            endcase
        return v;
    endfunction
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic send(input logic [7:0] d, input logic l, output int s);
        int n = 0;
        bus.i_valid = 1; bus.i_data = d; bus.i_last = l;
        #1;
        while (!bus.o_ready && n < 100) begin
            step(); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout got=no_ready exp=ready");
        end
        step();
        s = cyc;
        bus.i_valid = 0;
    endtask
    initial begin
        int s, s1, s2, s3, c;
        bus.i_enable = 0; bus.i_valid = 0; bus.i_data = '0; bus.i_last = 0;
        repeat (3) step();
        rst = 0; bus.i_enable = 1;
        step();
        send(8'hA5, 1, s);
        repeat (24) step();
        chkv("a5_data", gv(0, s, 16), 32'h00A5);
        chkv("a5_en", gv(1, s, 16), 32'h3FFF);
        chkv("a5_en_before", gv(1, s - 1, 1), 32'h0);
        chkv("a5_dflag", gv(2, s, 16), 32'h00FF);
        chkv("a5_enc_sof", gv(3, s, 16), 32'h0040);
        chkv("a5_enc_eof", gv(4, s, 16), 32'h2000);
        chkv("a5_enc_valid", gv(5, s, 16), 32'hFFC0);
        chkv("a5_busy_tail", gv(8, s + 19, 2), 32'h1);
        send(8'hFF, 0, s);
        send(8'h00, 0, s1);
        send(8'h81, 1, s2);
        repeat (36) step();
        chkv("b2b_gap1", s1 - s, 8);
        chkv("b2b_gap2", s2 - s, 16);
        chkv("b2b_ready", gv(6, s, 30), 32'h8080);
        chkv("b2b_data", gv(0, s, 30), 32'h008100FF);
        chkv("b2b_dflag", gv(2, s, 31), 32'h00FFFFFF);
        chkv("b2b_en", gv(1, s, 31), 32'h3FFFFFFF);
        send(8'h3C, 0, s);
        repeat (12) step();
        send(8'hC3, 1, s2);
        repeat (24) step();
        chkv("ur_msb_delay", s2 - s, 13);
        chkv("ur_data", gv(0, s, 21), 32'h18603C);
        chkv("ur_dflag", gv(2, s, 21), 32'h1FE0FF);
        chkv("ur_pulse", gv(7, s, 21), 32'h000100);
        chkv("ur_en", gv(1, s, 21), 32'h1FFFFF);
        bus.i_enable = 0; bus.i_valid = 1; bus.i_data = 8'hD2; bus.i_last = 1;
        repeat (5) step();
        c = cyc;
        chkv("en0_ready", gv(6, c - 4, 4), 32'h0);
        chkv("en0_ser_en", gv(1, c - 4, 4), 32'h0);
        bus.i_enable = 1;
        send(8'hD2, 1, s);
        repeat (18) step();
        chkv("en1_latency", s - c, 1);
        chkv("en1_first_bit", gv(1, s - 1, 2), 32'h2);
        chkv("en1_data", gv(0, s, 8), 32'h4B);
        send(8'h11, 0, s);
        send(8'hE7, 0, s2);
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        c = cyc;
        step();
        send(8'h96, 1, s3);
        repeat (22) step();
        chkv("rst_cycle", c - s2, 4);
        chkv("rst_en", gv(1, c - 1, 2), 32'h1);
        chkv("rst_enc_valid", gv(5, c, 1), 32'h0);
        chkv("rst_busy", gv(8, c, 1), 32'h0);
        chkv("rst_next_data", gv(0, s3, 8), 32'h69);
        chkv("rst_next_sof", gv(3, s3 + 6, 1), 32'h1);
        chkv("rst_next_eof", gv(4, s3 + 13, 1), 32'h1);
        bus.i_valid = 1; bus.i_data = 8'hFF; bus.i_last = 1; rst = 1;
        step();
        rst = 0; bus.i_valid = 0;
        c = cyc;
        repeat (4) step();
        chkv("rst_vs_accept", gv(1, c, 3), 32'h0);
        repeat (2500) begin
            bus.i_enable = $urandom_range(3) != 0;
            bus.i_valid  = $urandom_range(1) != 0;
            bus.i_data   = 8'($urandom);
            bus.i_last   = $urandom_range(5) == 0;
            rst          = $urandom_range(399) == 0;
            step();
        end
        rst = 0; bus.i_valid = 0;
        repeat (40) step();
        c = 0;
        while (!done2 && c < 200) begin
            step(); c++;
        end
        if (!done2) begin
            checks++; errors++;
            $display("FAIL p1_done got=0 exp=1");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        int s, n;
        bus2.i_enable = 0; bus2.i_valid = 0; bus2.i_data = '0; bus2.i_last = 0;
        repeat (3) step();
        rst2 = 0; bus2.i_enable = 1;
        step();
        bus2.i_valid = 1; bus2.i_data = 2'b10; bus2.i_last = 1;
        #1;
        n = 0;
        while (!bus2.o_ready && n < 20) begin
            step(); #1; n++;
        end
        step();
        s = cyc;
        bus2.i_valid = 0;
        repeat (8) step();
        chkv("p1_en", gv(11, s - 1, 5), 32'h0E);
        chkv("p1_data", gv(10, s, 2), 32'h1);
        chkv("p1_enc_sof", gv(13, s, 4), 32'h2);
        chkv("p1_enc_eof", gv(14, s, 4), 32'h4);
        chkv("p1_enc_valid", gv(15, s, 5), 32'h0E);
        done2 = 1;
    end
endmodule

// File: doc/hdb3_enc_ctrl.md
# hdb3_enc_ctrl

Burst sequencer in front of the HDB3 encoder chain (V-insertion, B-insertion, polarity stages). It accepts parallel words from an upstream source over a valid/ready handshake and serializes them MSB-first into the encoder's 1-bit input. It keeps the line running with zero bits on underrun and drains the encoder pipeline with zero bits after the last word. It also produces valid/SOF/EOF markers delayed to line up with the encoder's 2-bit output code.

## Interface
- DATA_W, 8, word width in bits (2..32)
- PIPE_LAT, 6, encoder chain latency in clocks from o_ser_data to encoded output; also the flush length in bits (1..15)
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_enable  input  1  permits a new burst to start from IDLE
- i_data  input  DATA_W  word to encode
- i_valid  input  1  i_data/i_last valid
- i_last  input  1  word is last of burst; qualified by acceptance
- o_ready  output  1  block accepts word this cycle (accept = i_valid & o_ready)
- o_ser_data  output  1  serial bit to encoder
- o_ser_en  output  1  o_ser_data is a line bit (data, fill or flush)
- o_ser_dflag  output  1  o_ser_data is a payload bit
- o_underrun  output  1  one-cycle pulse on entry to UNDERRUN
- o_enc_valid  output  1  o_ser_en delayed PIPE_LAT clocks
- o_enc_sof  output  1  first payload bit of burst, delayed PIPE_LAT
- o_enc_eof  output  1  last payload bit of burst, delayed PIPE_LAT
- o_busy  output  1  state != IDLE or any delay-line stage set

## Operation
- States: IDLE, SHIFT, UNDERRUN, FLUSH.
- IDLE: o_ready = i_enable. On accept, go to SHIFT. Latch i_data and i_last. Arm SOF for the first bit.
- SHIFT: emit one bit per clock, MSB first, DATA_W bits per word, with o_ser_en=1 and o_ser_dflag=1. Bit counter runs 0..DATA_W-1 and wraps.
  - o_ready=1 only in the cycle the last bit (count DATA_W-1) is on o_ser_data, and only if the latched last flag is 0.
  - Accept in that cycle: the next word's MSB follows with no gap.
  - No accept, last=0: go to UNDERRUN.
  - Last=1: go to FLUSH.
- UNDERRUN: emit 0 bits with o_ser_en=1 and o_ser_dflag=0. o_ready=1. On accept, return to SHIFT; that word's MSB appears the next cycle. i_last is honoured as in SHIFT. o_underrun pulses once, in the first UNDERRUN cycle.
- FLUSH: emit exactly PIPE_LAT 0 bits with o_ser_en=1 and o_ser_dflag=0, o_ready=0. Then go to IDLE.
- IDLE outputs: o_ser_en=0, o_ser_data=0, o_ser_dflag=0.
- EOF: set on the last bit of the word accepted with i_last=1. A single-word burst gets SOF on bit 0 and EOF on bit DATA_W-1.
- Delay lines: o_enc_valid, o_enc_sof and o_enc_eof are PIPE_LAT-deep shift registers fed by o_ser_en, the SOF marker and the EOF marker.
- i_enable low does not stop a burst in progress. It only gates o_ready in IDLE.
- i_data and i_last are ignored when o_ready=0.

## Timing
- All outputs are registered except o_ready, which is combinational from state, bit counter, last flag and i_enable.
- Accept at edge t: MSB is on o_ser_data in cycle t+1. Bit k is on o_ser_data in cycle t+1+k.
- Encoded output for bit k is aligned with o_enc_valid in cycle t+1+k+PIPE_LAT.
- Burst of N words, no underrun: o_ser_en is high for N*DATA_W + PIPE_LAT consecutive cycles. o_busy falls PIPE_LAT cycles after o_ser_en falls.
- A new burst may be accepted in the first IDLE cycle after FLUSH. The delay lines keep draining meanwhile and o_busy stays high.
- Reset: a synchronous i_rst at edge t returns to IDLE, clears the counters, latched word, last flag and all delay lines. From cycle t+1 every output is 0, except o_ready, which equals i_enable.
- Reset mid-burst discards the remainder without a flush.
- Reset has priority over a simultaneous accept.

## Test plan
- DATA_W=8, PIPE_LAT=6: one word 0xA5 with i_last=1.
  - o_ser_data = 1,0,1,0,0,1,0,1, then six 0s.
  - o_ser_en high for 14 cycles; o_ser_dflag high for the first 8.
  - o_enc_sof and o_enc_eof pulse 6 cycles after bits 0 and 7.
- Back-to-back 0xFF, 0x00, 0x81 (last on 0x81), valid held high:
  - o_ready high exactly once per word, at bit 7.
  - 24 contiguous payload bits, no gap, then 6 flush zeros.
- Underrun: 0x3C, then i_valid low for 5 cycles, then 0xC3 with last:
  - 5 fill zeros with o_ser_dflag=0.
  - o_underrun pulses once, in the first fill cycle.
  - 0xC3's MSB appears the cycle after its accept.
- i_enable=0 with i_valid=1 in IDLE: o_ready=0 and no bits are emitted. Raising i_enable makes the first bit appear one cycle after accept.
- Assert i_rst during bit 3 of the second word of a burst: next cycle o_ser_en=0, o_enc_valid=0, o_busy=0. A following burst encodes correctly from its bit 0.
- PIPE_LAT=1, DATA_W=2: single word 2'b10 with last gives o_ser_en high for 3 cycles, and o_enc_eof appears 1 cycle after bit 1.
